floo_id_xlat_sched: RTL
=======================

FLOO_ID_XLAT_SCHED -- requirements
Module: floo_id_xlat_sched

Interface
REQ-001 SHALL have parameter NumReq, default 2: number of requesters sharing one translation unit (2..8).
REQ-002 SHALL have parameter addr_t, default logic: request address type.
REQ-003 SHALL have parameter id_t, default logic: endpoint ID type.
REQ-004 SHALL have parameter mask_sel_t, default logic: multicast mask-select type.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have these ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: async active-high reset.
- req_valid_i, input, NumReq: per-requester request valid.
- req_ready_o, output, NumReq: per-requester request accept.
- req_addr_i, input, NumReq x addr_t: per-requester address.
- rsp_valid_o, output, NumReq: per-requester result valid.
- rsp_ready_i, input, NumReq: per-requester result accept.
- rsp_id_o, output, id_t: shared result ID.
- rsp_mask_x_o, output, mask_sel_t: shared X mask select.
- rsp_mask_y_o, output, mask_sel_t: shared Y mask select.
- xlat_valid_o, output, 1: qualifies the address sent to the translator.
- xlat_addr_o, output, addr_t: address to the translator.
- xlat_id_i, input, id_t: translator ID result (combinational from xlat_addr_o).
- xlat_mask_x_i, input, mask_sel_t: translator X mask.
- xlat_mask_y_i, input, mask_sel_t: translator Y mask.

Function
REQ-007 SHALL implement FSM states IDLE, XLAT and RESP.
REQ-008 In IDLE with any req_valid_i set, SHALL grant exactly one requester round-robin, searching upward from the priority pointer with wrap.
- req_ready_o[g] = 1 for the granted index only, same cycle.
- On that edge: register req_addr_i[g] and g; go to XLAT.
REQ-009 SHALL hold req_ready_o at 0 in XLAT and RESP, and in IDLE when no request is pending.
REQ-010 XLAT lasts exactly one cycle:
- xlat_valid_o = 1 and xlat_addr_o = registered address.
- On the edge: capture xlat_id_i, xlat_mask_x_i and xlat_mask_y_i; go to RESP.
REQ-011 In RESP, SHALL assert rsp_valid_o[g] only, with rsp_id_o and both masks stable, until rsp_ready_i[g] = 1; on that handshake go to IDLE.
REQ-012 Latency: request handshake in cycle N gives rsp_valid_o in cycle N+2; peak throughput is one request per 3 cycles.
REQ-013 SHALL ignore rsp_ready_i of non-granted requesters and SHALL ignore req_valid_i changes outside IDLE.
REQ-014 Priority pointer SHALL update to (g+1) mod NumReq on each grant; wrap from NumReq-1 goes to 0.
REQ-015 Outside XLAT, xlat_valid_o = 0 and xlat_addr_o keeps the last registered address.

Reset
REQ-016 Asserting rst_i SHALL immediately force:
- state IDLE, priority pointer 0;
- rsp_valid_o = 0, xlat_valid_o = 0;
- rsp_id_o, both masks and xlat_addr_o = 0.
REQ-017 Reset mid-XLAT or mid-RESP SHALL drop the in-flight request silently; the first grant after release goes to the lowest valid index.

Configuration
REQ-018 With macro FLOO_ID_XLAT_SCHED_PERF_EN defined:
- Output grant_cnt_o (NumReq x 16 bits) SHALL exist, one counter per requester.
- A counter increments on each grant to its requester and saturates at 0xFFFF.
- Counters reset to 0.
REQ-019 Without FLOO_ID_XLAT_SCHED_PERF_EN, neither the port nor the counters SHALL exist.

Structure
REQ-020 The state enum (IDLE/XLAT/RESP) SHALL be defined in floo_pkg.
REQ-021 Round-robin selection SHALL be one sub-module, floo_xlat_rr_pick: inputs are request vector and pointer; outputs are grant index and grant valid.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single request: req 0 with address 0x1000, translator returns ID 0x5 -> rsp_valid_o[0] two cycles after handshake, rsp_id_o = 0x5.
- Contention: req 0 and req 1 valid continuously from reset -> grants in order 0, 1, 0, 1, spaced 3 cycles apart with rsp_ready_i held at 1.
- Backpressure: rsp_ready_i[1] held at 0 for 5 cycles -> rsp_valid_o[1] and rsp_id_o stable, req_ready_o = 0 throughout.
- Wrap: NumReq = 4, only req 3 then req 0 valid -> pointer goes 0 to 0 after grant 3, then to 1 after grant 0.
- Reset in RESP: rst_i pulsed while rsp_valid_o[0] = 1 -> all outputs 0 immediately; the next grant goes to the lowest valid index.
- PERF enabled: 65537 grants to req 0 -> grant_cnt_o[0] = 0xFFFF.

Source files
------------

// File: rtl/floo_pkg.sv
// floo_pkg
//   Shared types for the ID translation scheduler.
//   - xlat_state_e : scheduler FSM state (IDLE -> XLAT -> RESP -> IDLE)
//   - GrantCntW    : width of the optional per-requester grant counters
//   - GrantCntMax  : saturation value of those counters
package floo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XLAT = 2'd1,
    RESP = 2'd2
  } xlat_state_e;

  localparam int unsigned GrantCntW = 16;
  localparam logic [GrantCntW-1:0] GrantCntMax = '1;

endpackage

// File: rtl/floo_xlat_rr_pick.sv
// floo_xlat_rr_pick
//   Combinational round-robin pick. Searches req_i upward starting at ptr_i,
//   wrapping past NumReq-1 back to 0, and returns the first set index.
//   Ports:
//     req_i       : request vector (NumReq bits)
//     ptr_i       : priority pointer, index searched first
//     gnt_idx_o   : selected index (0 when nothing is requested)
//     gnt_valid_o : at least one request is set
module floo_xlat_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  // Walk the offsets from farthest to nearest so the last hit written is the
  // one closest to the pointer.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NumReq;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/floo_id_xlat_sched.sv
// floo_id_xlat_sched
//   Shares one combinational ID translator among NumReq requesters.
//   A request is granted round-robin in IDLE, its address is presented to the
//   translator for one XLAT cycle, and the captured result is held in RESP
//   until the granted requester accepts it.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1 on the same channel. req_ready_o is combinational from
//   req_valid_i (only in IDLE); rsp_valid_o is held with stable payload until
//   rsp_ready_i of the granted requester is 1.
//
//   Ports:
//     clk_i, rst_i                 : clock, async active-high reset
//     req_valid_i/req_ready_o      : per-requester request handshake
//     req_addr_i                   : per-requester address
//     rsp_valid_o/rsp_ready_i      : per-requester result handshake
//     rsp_id_o, rsp_mask_x/y_o     : shared result payload
//     xlat_valid_o, xlat_addr_o    : address presented to the translator
//     xlat_id_i, xlat_mask_x/y_i   : translator result
//     grant_cnt_o                  : per-requester saturating grant counters,
//                                    only with FLOO_ID_XLAT_SCHED_PERF_EN
module floo_id_xlat_sched
  import floo_pkg::*;
#(
  parameter int unsigned NumReq     = 2,
  parameter type         addr_t     = logic,
  parameter type         id_t       = logic,
  parameter type         mask_sel_t = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic      [NumReq-1:0]          req_valid_i,
  output logic      [NumReq-1:0]          req_ready_o,
  input  addr_t                           req_addr_i [NumReq],
  output logic      [NumReq-1:0]          rsp_valid_o,
  input  logic      [NumReq-1:0]          rsp_ready_i,
  output id_t                             rsp_id_o,
  output mask_sel_t                       rsp_mask_x_o,
  output mask_sel_t                       rsp_mask_y_o,
  output logic                            xlat_valid_o,
  output addr_t                           xlat_addr_o,
  input  id_t                             xlat_id_i,
  input  mask_sel_t                       xlat_mask_x_i,
  input  mask_sel_t                       xlat_mask_y_i
`ifdef FLOO_ID_XLAT_SCHED_PERF_EN
  ,
  output logic      [NumReq-1:0][GrantCntW-1:0] grant_cnt_o
`endif
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  xlat_state_e     state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  addr_t           addr_q, addr_d;
  id_t             id_q, id_d;
  mask_sel_t       mask_x_q, mask_x_d;
  mask_sel_t       mask_y_q, mask_y_d;

  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic            grant_fire;

  floo_xlat_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_rr_pick (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_idx_o   (pick_idx),
    .gnt_valid_o (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    id_d         = id_q;
    mask_x_d     = mask_x_q;
    mask_y_d     = mask_y_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    xlat_valid_o = 1'b0;
    grant_fire   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Nothing is accepted while reset is held, so no request can appear
        // to complete during reset.
        if (pick_valid && !rst_i) begin
          grant_fire            = 1'b1;
          req_ready_o[pick_idx] = 1'b1;
          gnt_d                 = pick_idx;
          addr_d                = req_addr_i[pick_idx];
          ptr_d                 = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
          state_d               = XLAT;
        end
      end
      XLAT: begin
        xlat_valid_o = 1'b1;
        id_d         = xlat_id_i;
        mask_x_d     = xlat_mask_x_i;
        mask_y_d     = xlat_mask_y_i;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid_o[gnt_q] = 1'b1;
        if (rsp_ready_i[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      mask_x_q <= '0;
      mask_y_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      mask_x_q <= mask_x_d;
      mask_y_q <= mask_y_d;
    end
  end

  assign xlat_addr_o  = addr_q;
  assign rsp_id_o     = id_q;
  assign rsp_mask_x_o = mask_x_q;
  assign rsp_mask_y_o = mask_y_q;

`ifdef FLOO_ID_XLAT_SCHED_PERF_EN
  logic [NumReq-1:0][GrantCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_fire && (cnt_q[pick_idx] != GrantCntMax)) begin
      cnt_d[pick_idx] = cnt_q[pick_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule
